// File: rtl/case_5_mul_arb_pkg.sv
// Shared constants and record types for the case_5 shared-multiplier arbiter.
// The requester count and operand widths are fixed here for the whole slice.
package case_5_mul_arb_pkg;

  localparam int NUM_REQ    = 4;
  localparam int DIN0_WIDTH = 14;
  localparam int DIN1_WIDTH = 12;
  localparam int DOUT_WIDTH = 26;
  localparam int PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH;

  // Requester tag width: clog2 of the requester count, never below one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int ID_WIDTH = id_width(NUM_REQ);

  typedef struct packed {
    logic [DIN0_WIDTH-1:0] din0;
    logic [DIN1_WIDTH-1:0] din1;
    logic [ID_WIDTH-1:0]   id;
  } stage_t;

  typedef struct packed {
    logic [DOUT_WIDTH-1:0] dout;
    logic [ID_WIDTH-1:0]   id;
  } rsp_t;

endpackage

// File: rtl/case_5_rr_arb.sv
// Combinational round-robin grant: first asserted request at or after ptr,
// wrapping modulo N. Output is one-hot (or zero) plus the encoded index.
module case_5_rr_arb #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  always_comb begin
    logic found;
    int   j;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (en && !found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/case_5_mul_share_arb.sv
// One signed multiplier shared by NUM_REQ requesters: round-robin issue, operand
// stage A, product stage P. Optional perf counters under CASE_5_MUL_ARB_PERF_EN.
module case_5_mul_share_arb
  import case_5_mul_arb_pkg::*;
(
  input  logic                             ap_clk,
  input  logic                             ap_rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*DIN0_WIDTH-1:0]    req_din0,
  input  logic [NUM_REQ*DIN1_WIDTH-1:0]    req_din1,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [ID_WIDTH-1:0]              rsp_id,
  output logic [DOUT_WIDTH-1:0]            rsp_dout,
  output logic                             busy
`ifdef CASE_5_MUL_ARB_PERF_EN
  ,
  output logic [31:0]                      perf_issue_cnt,
  output logic [31:0]                      perf_stall_cnt
`endif
);

  // Handshake: a transfer happens on a cycle where valid & ready are both high.
  // Producers hold valid and data stable until then; ready never waits on valid
  // from the other side of the same channel except through the arbiter's request scan.

  stage_t                  a_q;
  logic                    a_vld;
  rsp_t                    p_q;
  logic                    p_vld;
  logic [ID_WIDTH-1:0]     ptr_q;
  logic [ID_WIDTH-1:0]     ptr_nxt;
  logic [NUM_REQ-1:0]      gnt;
  logic [ID_WIDTH-1:0]     gnt_idx;
  logic                    adv_p;
  logic                    a_free;
  logic                    xfer;
  logic [DIN0_WIDTH-1:0]   sel_din0;
  logic [DIN1_WIDTH-1:0]   sel_din1;
  logic signed [PROD_WIDTH-1:0] prod_full;
  logic [DOUT_WIDTH-1:0]   prod_out;

  assign adv_p  = !p_vld || rsp_ready;
  assign a_free = !a_vld || adv_p;

  // Gating with ap_rst keeps req_ready low for the whole reset pulse.
  case_5_rr_arb #(
    .N  (NUM_REQ),
    .IW (ID_WIDTH)
  ) u_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .en  (a_free && !ap_rst),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign xfer      = |gnt;
  assign sel_din0  = req_din0[gnt_idx*DIN0_WIDTH +: DIN0_WIDTH];
  assign sel_din1  = req_din1[gnt_idx*DIN1_WIDTH +: DIN1_WIDTH];
  assign ptr_nxt   = (gnt_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  // Size cast of a signed value wraps when narrowing and sign-extends when widening.
  assign prod_full = $signed(a_q.din0) * $signed(a_q.din1);
  assign prod_out  = DOUT_WIDTH'(prod_full);

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      ptr_q <= '0;
      a_q   <= '0;
      a_vld <= 1'b0;
      p_q   <= '0;
      p_vld <= 1'b0;
    end else begin
      if (xfer) begin
        ptr_q <= ptr_nxt;
        a_q   <= '{din0: sel_din0, din1: sel_din1, id: gnt_idx};
        a_vld <= 1'b1;
      end else if (adv_p) begin
        a_vld <= 1'b0;
      end
      if (adv_p) begin
        if (a_vld) begin
          p_q   <= '{dout: prod_out, id: a_q.id};
          p_vld <= 1'b1;
        end else begin
          p_vld <= 1'b0;
        end
      end
    end
  end

  assign rsp_valid = p_vld;
  assign rsp_id    = p_q.id;
  assign rsp_dout  = p_q.dout;
  assign busy      = a_vld || p_vld;

`ifdef CASE_5_MUL_ARB_PERF_EN
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (xfer) perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if ((|req_valid) && !(|req_ready)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_case_5_mul_share_arb.sv
// Self-checking bench for case_5_mul_share_arb: directed steps, a small
// issue/pipeline model and an expected-response queue.
`timescale 1ns/1ps
module tb_case_5_mul_share_arb;
  import case_5_mul_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [55:0] req_din0;
  logic [47:0] req_din1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [25:0] rsp_dout;
  logic        busy;
`ifdef CASE_5_MUL_ARB_PERF_EN
  logic [31:0] perf_issue_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  always #5 ap_clk = ~ap_clk;

  case_5_mul_share_arb dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_din0  (req_din0),
    .req_din1  (req_din1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_dout  (rsp_dout),
    .busy      (busy)
`ifdef CASE_5_MUL_ARB_PERF_EN
    ,
    .perf_issue_cnt (perf_issue_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  // ---------------- scoreboard / model state ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [27:0] exp_q[$];
  int          cnt[4];
  logic [13:0] d0[4];
  logic [11:0] d1[4];
  logic        rr_in;
  int          m_ptr;
  logic        m_av;
  logic        m_pv;
  int          m_issue;
  int          m_stall;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply();
    for (int i = 0; i < 4; i++) begin
      req_valid[i]          = (cnt[i] > 0);
      req_din0[i*14 +: 14]  = d0[i];
      req_din1[i*12 +: 12]  = d1[i];
    end
    rsp_ready = rr_in;
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_av    = 1'b0;
    m_pv    = 1'b0;
    m_issue = 0;
    m_stall = 0;
    exp_q.delete();
  endtask

  function automatic logic pending();
    for (int i = 0; i < 4; i++) if (cnt[i] > 0) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: check outputs at negedge against the model, then advance the
  // model past the rising edge and apply the requesters' next inputs.
  task automatic step();
    logic        adv;
    logic        afree;
    int          g;
    logic [3:0]  exp_rdy;
    logic [25:0] pd;
    int          a;
    int          b;
    @(negedge ap_clk);
    adv   = !m_pv || rr_in;
    afree = !m_av || adv;
    g     = afree ? rr_pick(req_valid, m_ptr) : -1;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("rsp_valid", 64'(rsp_valid), 64'(m_pv));
    chk("busy", 64'(busy), 64'(m_av | m_pv));
    if (m_pv) begin
      if (exp_q.size() == 0) chk("rsp_without_request", 64'(rsp_valid), 64'(0));
      else chk(rr_in ? "rsp_data" : "rsp_hold", 64'({rsp_id, rsp_dout}), 64'(exp_q[0]));
    end
    if ((|req_valid) && g < 0) m_stall++;
    @(posedge ap_clk);
    #1;
    if (m_pv && rr_in) void'(exp_q.pop_front());
    m_pv = adv ? m_av : m_pv;
    if (g >= 0) begin
      a  = $signed(d0[g]);
      b  = $signed(d1[g]);
      pd = 26'(a * b);
      exp_q.push_back({2'(g), pd});
      m_av  = 1'b1;
      m_ptr = (g + 1) % 4;
      m_issue++;
      cnt[g]--;
      d0[g] = 14'($urandom);
      d1[g] = 12'($urandom);
    end else if (adv) begin
      m_av = 1'b0;
    end
    apply();
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    rr_in = 1'b1;
    apply();
    while ((exp_q.size() > 0 || pending()) && n < budget) begin
      step();
      n++;
    end
    chk(tag, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic do_reset();
    ap_rst = 1'b1;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    rr_in = 1'b1;
    apply();
    model_reset();
    repeat (2) @(posedge ap_clk);
    #2 ap_rst = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    ap_rst = 1'b1;
    rr_in  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cnt[i] = 0;
      d0[i]  = '0;
      d1[i]  = '0;
    end
    model_reset();
    cnt[0] = 1;
    apply();
    #2;
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_id", 64'(rsp_id), 64'(0));
    chk("rst_rsp_dout", 64'(rsp_dout), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    cnt[0] = 0;
    apply();
    @(posedge ap_clk);
    #2 ap_rst = 1'b0;

    // Single request from requester 2: -3 * 7 = -21.
    d0[2] = 14'h3FFD; d1[2] = 12'd7; cnt[2] = 1;
    apply();
    drain("drain_single", 20);

    // All four requesters continuously valid from pointer 0.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      d0[i] = 14'($urandom); d1[i] = 12'($urandom); cnt[i] = 5;
    end
    apply();
    drain("drain_all4", 60);

    // Operand extremes.
    d0[0] = 14'h2000; d1[0] = 12'h800; cnt[0] = 1;
    d0[1] = 14'h1FFF; d1[1] = 12'h800; cnt[1] = 1;
    apply();
    drain("drain_extremes", 20);

    // Backpressure: three back-to-back issues, then five cycles of rsp_ready=0.
    for (int i = 0; i < 4; i++) cnt[i] = 2;
    rr_in = 1'b1;
    apply();
    repeat (3) step();
    rr_in = 1'b0;
    apply();
    repeat (5) step();
    drain("drain_backpressure", 40);

    // Random traffic and random consumer stalls.
    for (int c = 0; c < 150; c++) begin
      for (int i = 0; i < 4; i++) if (cnt[i] == 0 && $urandom_range(0, 3) == 0) cnt[i] = $urandom_range(1, 3);
      rr_in = ($urandom_range(0, 3) != 0);
      apply();
      step();
    end
    drain("drain_random", 120);

    // Asynchronous reset between clock edges with the pipeline loaded.
    for (int i = 0; i < 4; i++) cnt[i] = 3;
    rr_in = 1'b1;
    apply();
    repeat (3) step();
    @(negedge ap_clk);
    #2 ap_rst = 1'b1;
    #1;
    chk("arst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_req_ready", 64'(req_ready), 64'(0));
    chk("arst_rsp_dout", 64'(rsp_dout), 64'(0));
    model_reset();
    for (int i = 0; i < 4; i++) cnt[i] = 1;
    apply();
    @(posedge ap_clk);
    #1;
    chk("arst_hold_req_ready", 64'(req_ready), 64'(0));
    @(posedge ap_clk);
    #2 ap_rst = 1'b0;
    #1;
    chk("arst_first_grant", 64'(req_ready), 64'(4'b0001));
    drain("drain_after_reset", 40);

`ifdef CASE_5_MUL_ARB_PERF_EN
    chk("perf_issue_cnt", 64'(perf_issue_cnt), 64'(m_issue));
    chk("perf_stall_cnt", 64'(perf_stall_cnt), 64'(m_stall));
`endif

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    n_err++;
    $display("FAIL timeout observed=running expected=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
